// File: rtl/pipeline1_pkg.sv
// Shared constants for the instruction-fetch stage: datapath widths,
// the NOP encoding and the fetch state encodings.
package pipeline1_pkg;

    localparam int PC_WIDTH     = 16;
    localparam int INSTR_WIDTH  = 32;
    localparam int OPCODE_WIDTH = 6;

    localparam logic [OPCODE_WIDTH-1:0] NOP = 6'h14;

    // NOP opcode in the low opcode field, every other bit zero
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR =
        {{(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}, NOP};

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

endpackage

// File: rtl/pipeline1_hold_buf.sv
// fetch_hold_buf: one-entry instruction+PC buffer that parks a memory
// response which arrives while the fetch stage is stalled.
module fetch_hold_buf
    import pipeline1_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic                   load,
    input  logic                   clear,
    input  logic [INSTR_WIDTH-1:0] d_instr,
    input  logic [PC_WIDTH-1:0]    d_pc,
    output logic [INSTR_WIDTH-1:0] q_instr,
    output logic [PC_WIDTH-1:0]    q_pc,
    output logic                   valid
);

    // Clear beats load so a redirect or an advance always empties the entry
    always_ff @(posedge clk_in) begin
        if (!RST) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/pipeline1.sv
// pipeline1: instruction-fetch stage. Owns the PC, issues reads to a
// synchronous instruction memory, buffers a response across stalls and
// applies execute-stage redirects with a single NOP bubble.
module pipeline1
    import pipeline1_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic                   stall,
    input  logic                   br_en,
    input  logic [PC_WIDTH-1:0]    br_addr,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc_out
);

    logic [PC_WIDTH-1:0]    pc_q;
    logic                   inflight_q;
    logic [PC_WIDTH-1:0]    inflight_pc_q;
    logic [1:0]             state_q;
    logic [1:0]             state_d;

    logic                   hold_load;
    logic                   hold_clear;
    logic                   hold_valid_q;
    logic [INSTR_WIDTH-1:0] hold_q;
    logic [PC_WIDTH-1:0]    hold_pc_q;

    logic [PC_WIDTH-1:0]    pc_inc;
    logic [PC_WIDTH-1:0]    br_inc;

    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign br_inc = br_addr + PC_WIDTH'(1);

    // Read issue: a redirect fetches its target even when stalled; a stall suppresses the read
    always_comb begin
        imem_en   = 1'b1;
        imem_addr = pc_q;
        if (br_en) begin
            imem_en   = 1'b1;
            imem_addr = br_addr;
        end else if (stall) begin
            imem_en   = 1'b0;
            imem_addr = pc_q;
        end
    end

    // A response is parked only while stalled; any advance or redirect empties the buffer
    assign hold_load  = !br_en && stall && inflight_q;
    assign hold_clear = br_en || !stall;

    fetch_hold_buf u_hold (
        .clk_in  (clk_in),
        .RST     (RST),
        .load    (hold_load),
        .clear   (hold_clear),
        .d_instr (imem_data),
        .d_pc    (inflight_pc_q),
        .q_instr (hold_q),
        .q_pc    (hold_pc_q),
        .valid   (hold_valid_q)
    );

    // Next fetch state: redirect forces RUN, otherwise RUN/STALL tracks the stall input
    always_comb begin
        state_d = S_BOOT;
        unique case (state_q)
            S_BOOT, S_RUN, S_STALL: state_d = stall ? S_STALL : S_RUN;
            default:                state_d = stall ? S_STALL : S_RUN;
        endcase
        if (br_en) begin
            state_d = S_RUN;
        end
    end

    // PC, in-flight tracking and registered outputs toward decode
    always_ff @(posedge clk_in) begin
        if (!RST) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            instr         <= NOP_INSTR;
            pc_out        <= '0;
            state_q       <= S_BOOT;
        end else if (br_en) begin
            pc_q          <= br_inc;
            inflight_q    <= 1'b1;
            inflight_pc_q <= br_inc;
            instr         <= NOP_INSTR;
            pc_out        <= '0;
            state_q       <= state_d;
        end else if (stall) begin
            inflight_q    <= 1'b0;
            state_q       <= state_d;
        end else begin
            if (hold_valid_q) begin
                instr  <= hold_q;
                pc_out <= hold_pc_q;
            end else if (inflight_q) begin
                instr  <= imem_data;
                pc_out <= inflight_pc_q;
            end else begin
                instr  <= NOP_INSTR;
                pc_out <= '0;
            end
            pc_q          <= pc_inc;
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_inc;
            state_q       <= state_d;
        end
    end

endmodule

// File: tb/tb_pipeline1.sv
// Testbench for pipeline1: directed vector table for the documented
// sequences, then randomized traffic against a queue-based fetch model.
module tb_pipeline1;
    import pipeline1_pkg::*;

    logic                   clk_in;
    logic                   RST;
    logic                   stall;
    logic                   br_en;
    logic [PC_WIDTH-1:0]    br_addr;
    logic                   imem_en;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc_out;

    int checks = 0;
    int errors = 0;

    pipeline1 #(.RESET_PC(16'd0)) dut (
        .clk_in    (clk_in),
        .RST       (RST),
        .stall     (stall),
        .br_en     (br_en),
        .br_addr   (br_addr),
        .imem_en   (imem_en),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .instr     (instr),
        .pc_out    (pc_out)
    );

    // Clock generation
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] memWord(input logic [15:0] a);
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    // Synchronous instruction memory: data valid one cycle after an enabled read
    always @(posedge clk_in) begin
        if (imem_en) imem_data <= memWord(imem_addr);
    end

    // Reference model: a queue of fetched-but-not-delivered words
    typedef struct {
        logic [31:0] w;
        logic [15:0] p;
    } word_t;

    word_t       mdlQ[$];
    logic [15:0] mdlPc;
    logic [31:0] mdlInstr;
    logic [15:0] mdlPcOut;
    bit          modelValid = 0;

    task automatic modelStep(input logic r, input logic s, input logic b, input logic [15:0] a);
        word_t e;
        if (!r) begin
            mdlQ.delete();
            mdlPc    = 16'd0;
            mdlInstr = NOP_INSTR;
            mdlPcOut = 16'd0;
            modelValid = 1;
        end else if (b) begin
            mdlQ.delete();
            e.w = memWord(a);
            e.p = a + 16'd1;
            mdlQ.push_back(e);
            mdlPc    = a + 16'd1;
            mdlInstr = NOP_INSTR;
            mdlPcOut = 16'd0;
        end else if (!s) begin
            if (mdlQ.size() > 0) begin
                e = mdlQ.pop_front();
                mdlInstr = e.w;
                mdlPcOut = e.p;
            end else begin
                mdlInstr = NOP_INSTR;
                mdlPcOut = 16'd0;
            end
            e.w = memWord(mdlPc);
            e.p = mdlPc + 16'd1;
            mdlQ.push_back(e);
            mdlPc = mdlPc + 16'd1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the read port before the edge, advance the model on the edge
    task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [15:0] a);
        logic        expEn;
        logic [15:0] expAddr;
        @(negedge clk_in);
        RST     = r;
        stall   = s;
        br_en   = b;
        br_addr = a;
        #1;
        if (modelValid) begin
            expEn   = b ? 1'b1 : !s;
            expAddr = b ? a : mdlPc;
            checkOutput("imem_en", {31'd0, imem_en}, {31'd0, expEn});
            checkOutput("imem_addr", {16'd0, imem_addr}, {16'd0, expAddr});
        end
        @(posedge clk_in);
        modelStep(r, s, b, a);
        #1;
    endtask

    typedef struct {
        logic        rstN;
        logic        stl;
        logic        br;
        logic [15:0] addr;
        logic [31:0] expInstr;
        logic [15:0] expPc;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [15:0] a,
                                input logic [31:0] ei, input logic [15:0] ep);
        vec_t v;
        v.rstN = r; v.stl = s; v.br = b; v.addr = a; v.expInstr = ei; v.expPc = ep;
        return v;
    endfunction

    initial begin
        RST = 1'b0; stall = 1'b0; br_en = 1'b0; br_addr = '0;

        // Reset and run from 0
        tbl[0]  = mk(0, 0, 0, 0,     NOP_INSTR,         16'd0);
        tbl[1]  = mk(1, 0, 0, 0,     NOP_INSTR,         16'd0);
        tbl[2]  = mk(1, 0, 0, 0,     memWord(0),        16'd1);
        tbl[3]  = mk(1, 0, 0, 0,     memWord(1),        16'd2);
        tbl[4]  = mk(1, 0, 0, 0,     memWord(2),        16'd3);
        tbl[5]  = mk(1, 0, 0, 0,     memWord(3),        16'd4);
        tbl[6]  = mk(1, 0, 0, 0,     memWord(4),        16'd5);
        // Three-cycle stall with mem[5] in flight
        tbl[7]  = mk(1, 1, 0, 0,     memWord(4),        16'd5);
        tbl[8]  = mk(1, 1, 0, 0,     memWord(4),        16'd5);
        tbl[9]  = mk(1, 1, 0, 0,     memWord(4),        16'd5);
        tbl[10] = mk(1, 0, 0, 0,     memWord(5),        16'd6);
        tbl[11] = mk(1, 0, 0, 0,     memWord(6),        16'd7);
        // Plain redirect to 758
        tbl[12] = mk(1, 0, 1, 758,   NOP_INSTR,         16'd0);
        tbl[13] = mk(1, 0, 0, 0,     memWord(758),      16'd759);
        tbl[14] = mk(1, 0, 0, 0,     memWord(759),      16'd760);
        // Redirect together with stall, then a stall buffering the target
        tbl[15] = mk(1, 1, 1, 1024,  NOP_INSTR,         16'd0);
        tbl[16] = mk(1, 1, 0, 0,     NOP_INSTR,         16'd0);
        tbl[17] = mk(1, 0, 0, 0,     memWord(1024),     16'd1025);
        tbl[18] = mk(1, 0, 0, 0,     memWord(1025),     16'd1026);
        // PC wrap
        tbl[19] = mk(1, 0, 1, 65534, NOP_INSTR,         16'd0);
        tbl[20] = mk(1, 0, 0, 0,     memWord(65534),    16'd65535);
        tbl[21] = mk(1, 0, 0, 0,     memWord(65535),    16'd0);
        tbl[22] = mk(1, 0, 0, 0,     memWord(0),        16'd1);
        // Reset during a stall with the buffer full
        tbl[23] = mk(1, 1, 0, 0,     memWord(0),        16'd1);
        tbl[24] = mk(0, 1, 0, 0,     NOP_INSTR,         16'd0);
        tbl[25] = mk(1, 0, 0, 0,     NOP_INSTR,         16'd0);
        tbl[26] = mk(1, 0, 0, 0,     memWord(0),        16'd1);
        tbl[27] = mk(1, 0, 0, 0,     memWord(1),        16'd2);

        for (int i = 0; i < 28; i++) begin
            applyStimulus(tbl[i].rstN, tbl[i].stl, tbl[i].br, tbl[i].addr);
            checkOutput($sformatf("vec%0d instr", i), instr, tbl[i].expInstr);
            checkOutput($sformatf("vec%0d pc_out", i), {16'd0, pc_out}, {16'd0, tbl[i].expPc});
        end

        // Randomized traffic against the model
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 400; i++) begin
            logic r, s, b;
            logic [15:0] a;
            r = ($urandom_range(0, 31) != 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            a = 16'($urandom);
            applyStimulus(r, s, b, a);
            checkOutput($sformatf("rnd%0d instr", i), instr, mdlInstr);
            checkOutput($sformatf("rnd%0d pc_out", i), {16'd0, pc_out}, {16'd0, mdlPcOut});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
